// File: rtl/vx_gpu_pkg.sv
// Shared GPU definitions for the commit path.
// Holds the commit beat layout (commit_data_t), its width function and the
// field widths it is built from. The sop/eop flags sit in the two LSBs so
// that consumers can find them at a fixed position for any lane count.
package vx_gpu_pkg;

    localparam int unsigned SIMD_WIDTH = 4;
    localparam int unsigned UUID_W     = 44;
    localparam int unsigned LID_W      = 2;
    localparam int unsigned WID_W      = 4;
    localparam int unsigned SID_W      = 1;
    localparam int unsigned PC_W       = 32;
    localparam int unsigned RD_W       = 5;
    localparam int unsigned XLEN       = 32;

    // Bit position of eop inside a commit beat.
    localparam int unsigned EOP_BIT    = 0;

    // Commit beat width for a given lane count.
    function automatic int unsigned commit_dataw(input int unsigned lanes);
        return UUID_W + LID_W + WID_W + SID_W + lanes + PC_W + 1 + RD_W
             + lanes * XLEN + 2;
    endfunction

    localparam int unsigned COMMIT_DATAW = commit_dataw(SIMD_WIDTH);

    // Commit beat for the default lane count; sop/eop last so eop is bit 0.
    typedef struct packed {
        logic [UUID_W-1:0]          uuid;
        logic [LID_W-1:0]           lid;
        logic [WID_W-1:0]           wid;
        logic [SID_W-1:0]           sid;
        logic [SIMD_WIDTH-1:0]      tmask;
        logic [PC_W-1:0]            pc;
        logic                       wb;
        logic [RD_W-1:0]            rd;
        logic [SIMD_WIDTH*XLEN-1:0] data;
        logic                       sop;
        logic                       eop;
    } commit_data_t;

endpackage

// File: rtl/vx_commit_skid.sv
// Two-entry elastic buffer placed on the merged commit output.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   enq_valid/enq_data/enq_ready   upstream side; enq_ready is registered
//   deq_valid/deq_data/deq_ready   downstream side
// enq_ready depends only on occupancy, so no combinational path runs from
// deq_ready back to the upstream handshake.
module vx_commit_skid
    import vx_gpu_pkg::*;
#(
    parameter int unsigned W = COMMIT_DATAW
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enq_valid,
    input  logic [W-1:0] enq_data,
    output logic         enq_ready,
    output logic         deq_valid,
    output logic [W-1:0] deq_data,
    input  logic         deq_ready
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign push      = enq_valid && enq_ready;
    assign pop       = deq_valid && deq_ready;
    assign enq_ready = (count != 2'd2);
    assign deq_valid = (count != 2'd0);
    assign deq_data  = mem[rd_ptr];

    // Storage and pointers; entries are cleared so the output reads zero after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enq_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/vx_commit_arb.sv
// Commit-stream arbiter: merges NUM_INPUTS commit channels into one.
// Multi-beat packets (sop..eop) are kept atomic by locking the grant to the
// owning input until its eop beat transfers; the round-robin pointer moves
// past an input when its packet completes.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   in_valid/in_data/in_ready   per-channel commit beats (flattened data)
//   out_valid/out_data/out_ready merged commit beat toward writeback
//   out_sel             source index travelling with out_data
//   perf_retired        count of eop beats accepted downstream (wrapping)
// OUT_REG=0 gives a zero-latency combinational output; OUT_REG=1 inserts a
// two-entry skid buffer so in_ready no longer depends on out_ready.
module vx_commit_arb
    import vx_gpu_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned NUM_LANES  = SIMD_WIDTH,
    parameter int unsigned OUT_REG    = 1,
    parameter int unsigned PERF_W     = 32,
    localparam int unsigned DATAW     = commit_dataw(NUM_LANES),
    localparam int unsigned SEL_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_INPUTS-1:0]       in_valid,
    input  logic [NUM_INPUTS*DATAW-1:0] in_data,
    output logic [NUM_INPUTS-1:0]       in_ready,
    output logic                        out_valid,
    output logic [DATAW-1:0]            out_data,
    output logic [SEL_W-1:0]            out_sel,
    input  logic                        out_ready,
    output logic [PERF_W-1:0]           perf_retired
);

    // Arbiter state
    logic             lock;
    logic             lock_next;
    logic [SEL_W-1:0] lock_idx;
    logic [SEL_W-1:0] lock_idx_next;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_ptr_next;

    // Grant and selected beat
    logic             hi_any;
    logic [SEL_W-1:0] hi_idx;
    logic             lo_any;
    logic [SEL_W-1:0] lo_idx;
    logic             gnt_any;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic [DATAW-1:0] gnt_data;
    logic             stage_ready;
    logic             xfer;

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock     <= 1'b0;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else begin
            lock     <= lock_next;
            lock_idx <= lock_idx_next;
            rr_ptr   <= rr_ptr_next;
        end
    end

    // Round-robin search split in two: lowest valid at/above rr_ptr (hi),
    // otherwise lowest valid overall (lo), which is the wrapped-around winner.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_any = 1'b0;
        lo_idx = '0;
        for (int i = int'(NUM_INPUTS) - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                lo_any = 1'b1;
                lo_idx = SEL_W'(i);
                if (i >= int'(rr_ptr)) begin
                    hi_any = 1'b1;
                    hi_idx = SEL_W'(i);
                end
            end
        end
    end

    // Grant: a locked input owns the channel whether or not it is valid.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (lock) begin
            gnt_any = 1'b1;
            gnt_idx = lock_idx;
        end else if (hi_any) begin
            gnt_any = 1'b1;
            gnt_idx = hi_idx;
        end else if (lo_any) begin
            gnt_any = 1'b1;
            gnt_idx = lo_idx;
        end
    end

    // Select the granted beat and drive per-channel ready.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_data  = '0;
        in_ready  = '0;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            if (gnt_any && (gnt_idx == SEL_W'(i))) begin
                gnt_valid   = in_valid[i];
                gnt_data    = in_data[i*DATAW +: DATAW];
                in_ready[i] = reset_n && stage_ready;
            end
        end
    end

    assign xfer = reset_n && gnt_valid && stage_ready;

    // Lock and round-robin advance on the input-side transfer; sop is ignored,
    // so a stray sop inside a locked packet is just a continuation beat.
    always_comb begin
        lock_next     = lock;
        lock_idx_next = lock_idx;
        rr_ptr_next   = rr_ptr;
        if (xfer) begin
            if (gnt_data[EOP_BIT]) begin
                lock_next   = 1'b0;
                rr_ptr_next = (gnt_idx == SEL_W'(NUM_INPUTS - 1)) ? '0
                                                                   : gnt_idx + SEL_W'(1);
            end else begin
                lock_next     = 1'b1;
                lock_idx_next = gnt_idx;
            end
        end
    end

    // Output stage.
    if (OUT_REG != 0) begin : g_skid
        logic [SEL_W+DATAW-1:0] q_data;

        vx_commit_skid #(
            .W (SEL_W + DATAW)
        ) u_skid (
            .clk       (clk),
            .reset_n   (reset_n),
            .enq_valid (reset_n && gnt_valid),
            .enq_data  ({gnt_idx, gnt_data}),
            .enq_ready (stage_ready),
            .deq_valid (out_valid),
            .deq_data  (q_data),
            .deq_ready (out_ready)
        );

        assign {out_sel, out_data} = q_data;
    end else begin : g_comb
        assign stage_ready = out_ready;
        assign out_valid   = reset_n && gnt_valid;
        assign out_data    = (reset_n && gnt_valid) ? gnt_data : '0;
        assign out_sel     = (reset_n && gnt_valid) ? gnt_idx  : '0;
    end

    // Retired-packet counter: eop beats accepted downstream, wrapping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_retired <= '0;
        end else if (out_valid && out_ready && out_data[EOP_BIT]) begin
            perf_retired <= perf_retired + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_vx_commit_arb.sv
// Bench for vx_commit_arb: a 4-input registered-output instance checked
// cycle by cycle against a packet-level model, plus a 1-input zero-latency
// instance checked for pass-through behaviour.
module tb_vx_commit_arb;
    import vx_gpu_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = COMMIT_DATAW;

    typedef struct packed {
        logic [1:0]   sel;
        commit_data_t data;
    } ob_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;
    logic [3:0]     perf_retired;

    logic [0:0]     z_in_valid;
    logic [W-1:0]   z_in_data;
    logic [0:0]     z_in_ready;
    logic           z_out_valid;
    logic [W-1:0]   z_out_data;
    logic [0:0]     z_out_sel;
    logic           z_out_ready;
    logic [31:0]    z_perf;

    vx_commit_arb #(.NUM_INPUTS(4), .NUM_LANES(SIMD_WIDTH), .OUT_REG(1), .PERF_W(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready), .perf_retired(perf_retired)
    );

    vx_commit_arb #(.NUM_INPUTS(1), .NUM_LANES(SIMD_WIDTH), .OUT_REG(0), .PERF_W(32)) u_zl (
        .clk(clk), .reset_n(reset_n), .in_valid(z_in_valid), .in_data(z_in_data),
        .in_ready(z_in_ready), .out_valid(z_out_valid), .out_data(z_out_data),
        .out_sel(z_out_sel), .out_ready(z_out_ready), .perf_retired(z_perf)
    );

    // Model: per-input source queues, in-flight beats, packet owner and priority.
    commit_data_t src_q[N][$];
    ob_t          sb[$];
    int           obs_sel[$];
    int           m_owner;
    int           m_prio;
    int           m_retired;
    int           acc_cnt;
    logic [N-1:0] obs_ready;
    bit           gaps;
    bit           rnd_ready;
    int           n_chk = 0;
    int           n_fail = 0;

    function automatic commit_data_t make_beat(input logic sop, input logic eop);
        logic [W-1:0] r;
        commit_data_t b;
        r = '0;
        for (int k = 0; k < int'((W + 31) / 32); k++) r = (r << 32) | W'($urandom);
        b     = r;
        b.sop = sop;
        b.eop = eop;
        return b;
    endfunction

    task automatic add_packet(input int i, input int len, input bit mid_sop);
        for (int j = 0; j < len; j++) begin
            src_q[i].push_back(make_beat((j == 0) || (mid_sop && $urandom_range(0, 3) == 0),
                                         j == len - 1));
        end
    endtask

    function automatic bit pending();
        bit p;
        p = (sb.size() > 0) || (in_valid != '0);
        for (int i = 0; i < int'(N); i++) if (src_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    // Held valids stay up until they transfer; new beats may be delayed when gaps is set.
    task automatic drive_inputs(input logic [N-1:0] fired);
        for (int i = 0; i < int'(N); i++) begin
            if (!(in_valid[i] && !fired[i]))
                in_valid[i] = (src_q[i].size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
            in_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
        if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
    endtask

    // One clock in lockstep with the model: compare at negedge, update after posedge.
    task automatic step(input string tag);
        int           g;
        logic         acc;
        logic [N-1:0] er;
        logic [N-1:0] fired;
        bit           out_fire;
        ob_t          ob;
        @(negedge clk);
        g = -1;
        if (m_owner >= 0) g = m_owner;
        else for (int k = 0; k < int'(N); k++)
            if (g < 0 && in_valid[(m_prio + k) % N]) g = (m_prio + k) % N;
        acc = (sb.size() < 2);
        er  = '0;
        if (g >= 0 && acc) er[g] = 1'b1;
        obs_ready = in_ready;
        n_chk++;
        if (in_ready !== er) begin
            n_fail++;
            $display("FAIL %s in_ready: got %b want %b", tag, in_ready, er);
        end
        n_chk++;
        if (out_valid !== (sb.size() > 0)) begin
            n_fail++;
            $display("FAIL %s out_valid: got %b want %b", tag, out_valid, sb.size() > 0);
        end
        if (sb.size() > 0) begin
            n_chk++;
            if ({out_sel, out_data} !== sb[0]) begin
                n_fail++;
                $display("FAIL %s out beat: got sel %0d data %h want sel %0d data %h",
                         tag, out_sel, out_data, sb[0].sel, sb[0].data);
            end
        end
        n_chk++;
        if (perf_retired !== 4'(m_retired % 16)) begin
            n_fail++;
            $display("FAIL %s perf_retired: got %0d want %0d", tag, perf_retired, m_retired % 16);
        end
        out_fire = (sb.size() > 0) && out_ready;
        fired = '0;
        @(posedge clk);
        #1;
        if (out_fire) begin
            ob = sb.pop_front();
            obs_sel.push_back(int'(ob.sel));
            if (ob.data.eop) m_retired++;
        end
        if (g >= 0 && in_valid[g] && acc) begin
            ob.sel  = 2'(g);
            ob.data = src_q[g].pop_front();
            sb.push_back(ob);
            fired[g] = 1'b1;
            acc_cnt++;
            if (ob.data.eop) begin
                m_owner = -1;
                m_prio  = (g + 1) % N;
            end else begin
                m_owner = g;
            end
        end
        drive_inputs(fired);
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        while (pending() && cyc < 400) begin
            step(tag);
            cyc++;
        end
        n_chk++;
        if (pending()) begin
            n_fail++;
            $display("FAIL %s drain: got beats still pending after %0d cycles want none", tag, cyc);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(N); i++) src_q[i].delete();
        sb.delete();
        obs_sel.delete();
        m_owner   = -1;
        m_prio    = 0;
        m_retired = 0;
        acc_cnt   = 0;
    endtask

    task automatic apply_reset();
        reset_n     = 1'b0;
        in_valid    = '0;
        in_data     = '0;
        out_ready   = 1'b1;
        z_in_valid  = '0;
        z_in_data   = '0;
        z_out_ready = 1'b0;
        gaps        = 1'b0;
        rnd_ready   = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== '0 || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got valid %b ready %b sel %0d want 0 0 0",
                     out_valid, in_ready, out_sel);
        end
        n_chk++;
        if (out_data !== '0 || perf_retired !== 4'd0) begin
            n_fail++;
            $display("FAIL reset data/perf: got %h / %0d want 0 / 0", out_data, perf_retired);
        end
        n_chk++;
        if (u_dut.lock !== 1'b0 || u_dut.rr_ptr !== 2'd0) begin
            n_fail++;
            $display("FAIL reset state: got lock %b rr_ptr %0d want 0 0", u_dut.lock, u_dut.rr_ptr);
        end
        // Valid inputs during reset must not see a ready.
        reset_n  = 1'b0;
        in_valid = '1;
        #1;
        n_chk++;
        if (in_ready !== '0) begin
            n_fail++;
            $display("FAIL reset in_ready held: got %b want 0000", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = '0;
        reset_n  = 1'b1;
    endtask

    task automatic test_rr_single_beat();
        int exp_sel[5] = '{0, 1, 2, 3, 0};
        int cyc = 0;
        apply_reset();
        for (int i = 0; i < int'(N); i++) repeat (2) add_packet(i, 1, 1'b0);
        drive_inputs('0);
        while (obs_sel.size() < 5 && cyc < 50) begin
            step("rr");
            cyc++;
        end
        n_chk++;
        if (obs_sel.size() < 5) begin
            n_fail++;
            $display("FAIL rr timeout: got %0d beats want 5", obs_sel.size());
        end else begin
            n_chk++;
            if (perf_retired !== 4'd5) begin
                n_fail++;
                $display("FAIL rr perf_retired: got %0d want 5", perf_retired);
            end
            for (int k = 0; k < 5; k++) begin
                n_chk++;
                if (obs_sel[k] !== exp_sel[k]) begin
                    n_fail++;
                    $display("FAIL rr out_sel[%0d]: got %0d want %0d", k, obs_sel[k], exp_sel[k]);
                end
            end
        end
        drain("rr");
    endtask

    task automatic test_atomicity();
        int exp_sel[6] = '{0, 1, 1, 1, 2, 0};
        apply_reset();
        add_packet(0, 1, 1'b0);
        drive_inputs('0);
        step("atom");
        add_packet(1, 3, 1'b0);
        add_packet(0, 1, 1'b0);
        add_packet(2, 1, 1'b0);
        drive_inputs('0);
        for (int k = 0; k < 3; k++) begin
            step("atom");
            n_chk++;
            if (obs_ready[0] !== 1'b0 || obs_ready[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL atom stall beat %0d: got in_ready %b want x0x0 pattern with 0,2 low",
                         k, obs_ready);
            end
        end
        drain("atom");
        n_chk++;
        if (obs_sel.size() != 6) begin
            n_fail++;
            $display("FAIL atom beat count: got %0d want 6", obs_sel.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_chk++;
                if (obs_sel[k] !== exp_sel[k]) begin
                    n_fail++;
                    $display("FAIL atom out_sel[%0d]: got %0d want %0d", k, obs_sel[k], exp_sel[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        repeat (4) add_packet(0, 1, 1'b0);
        drive_inputs('0);
        repeat (4) step("bp");
        n_chk++;
        if (acc_cnt !== 2) begin
            n_fail++;
            $display("FAIL bp accepted: got %0d want 2", acc_cnt);
        end
        n_chk++;
        if (obs_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp in_ready when full: got %b want 0", obs_ready[0]);
        end
        out_ready = 1'b1;
        drain("bp");
        n_chk++;
        if (obs_sel.size() != 4) begin
            n_fail++;
            $display("FAIL bp delivered: got %0d want 4", obs_sel.size());
        end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        for (int k = 0; k < 17; k++) add_packet(k % N, 1, 1'b0);
        drive_inputs('0);
        drain("wrap");
        n_chk++;
        if (perf_retired !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap perf_retired: got %0d want 1", perf_retired);
        end
    endtask

    task automatic test_reset_mid_packet();
        int cyc = 0;
        apply_reset();
        add_packet(1, 1, 1'b0);
        drive_inputs('0);
        step("rst_mid");
        add_packet(3, 4, 1'b0);
        drive_inputs('0);
        while (acc_cnt < 3 && cyc < 20) begin
            step("rst_mid");
            cyc++;
        end
        reset_n  = 1'b0;
        in_valid = '0;
        clear_model();
        @(posedge clk);
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== '0) begin
            n_fail++;
            $display("FAIL rst_mid outputs: got valid %b ready %b want 0 0000", out_valid, in_ready);
        end
        n_chk++;
        if (u_dut.lock !== 1'b0 || u_dut.rr_ptr !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_mid state: got lock %b rr_ptr %0d want 0 0", u_dut.lock, u_dut.rr_ptr);
        end
        reset_n = 1'b1;
        for (int i = 0; i < int'(N); i++) add_packet(i, 1, 1'b0);
        drive_inputs('0);
        step("rst_mid");
        n_chk++;
        if (obs_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid first grant: got %b want 0001", obs_ready);
        end
        drain("rst_mid");
    endtask

    task automatic test_zero_latency();
        commit_data_t b;
        logic         rdy;
        int           z_exp = 0;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            b           = make_beat(1'b1, 1'($urandom_range(0, 1)));
            rdy         = 1'($urandom_range(0, 1));
            z_in_valid  = 1'b1;
            z_in_data   = b;
            z_out_ready = rdy;
            #1;
            n_chk++;
            if (z_out_valid !== 1'b1 || z_out_data !== b || z_out_sel !== 1'b0) begin
                n_fail++;
                $display("FAIL zl pass-through %0d: got v %b sel %0d data %h want 1 0 %h",
                         k, z_out_valid, z_out_sel, z_out_data, b);
            end
            n_chk++;
            if (z_in_ready !== rdy) begin
                n_fail++;
                $display("FAIL zl in_ready %0d: got %b want %b", k, z_in_ready, rdy);
            end
            if (rdy && b.eop) z_exp++;
            @(posedge clk);
            #1;
        end
        z_in_valid = 1'b0;
        #1;
        n_chk++;
        if (z_out_valid !== 1'b0 || z_perf !== 32'(z_exp)) begin
            n_fail++;
            $display("FAIL zl idle/perf: got v %b perf %0d want 0 %0d", z_out_valid, z_perf, z_exp);
        end
    endtask

    task automatic test_random();
        apply_reset();
        gaps      = 1'b1;
        rnd_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < int'(N); i++)
                if (src_q[i].size() < 2 && $urandom_range(0, 2) == 0)
                    add_packet(i, $urandom_range(1, 4), 1'b1);
            step("random");
        end
        gaps      = 1'b0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        drain("random");
    endtask

    initial begin
        test_reset();
        test_rr_single_beat();
        test_atomicity();
        test_backpressure();
        test_counter_wrap();
        test_reset_mid_packet();
        test_zero_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
